fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter ADDR, default 3, memory address width (depth 2^ADDR).
REQ-003 SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-004 SHALL have parameter BURST, default 4, maximum consecutive grants per requester (burst mode only).
REQ-005 SHALL have port wclk  in  1  write-domain clock.
REQ-006 SHALL have port wrst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  in  NREQ  per-requester write request.
REQ-008 SHALL have port req_data  in  NREQ*WIDTH  requester words, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port wq2_rptr  in  ADDR+1  Gray read pointer, already synchronized into wclk.
REQ-010 SHALL have port gnt  out  NREQ  one-hot grant; the granted word is written this cycle.
REQ-011 SHALL have port wclken  out  1  memory write enable.
REQ-012 SHALL have port wdata  out  WIDTH  memory write data.
REQ-013 SHALL have port waddr  out  ADDR  memory write address.
REQ-014 SHALL have port wptr  out  ADDR+1  Gray write pointer, for synchronization into the read domain.
REQ-015 SHALL have port wfull  out  1  FIFO full, registered.
REQ-016 SHALL have port wovf  out  1  sticky flag: request presented while full.

Function
REQ-017 gnt SHALL be combinational: the first asserted req searching upward from rr_ptr (modulo NREQ); all-zero when wfull=1 or no req.
REQ-018 wclken SHALL equal OR of gnt; wdata SHALL be req_data of the granted requester, zero when none.
REQ-019 waddr SHALL equal the lower ADDR bits of the internal binary write counter wbin (ADDR+1 bits).
REQ-020 On each edge with wclken=1, wbin SHALL increment by 1, wrapping 2^(ADDR+1)-1 -> 0; wptr SHALL register Gray(wbin+1).
REQ-021 Without a write, wbin and wptr SHALL hold.
REQ-022 wfull SHALL register (Gray of next wbin) == {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]} every edge; assertion follows the filling write by 0 extra cycles (same edge); deassertion follows a wq2_rptr change by one edge.
REQ-023 On a write, rr_ptr SHALL become (winner+1) mod NREQ; otherwise hold.
REQ-024 wovf SHALL set on any edge where wfull=1 and |req=1, cleared only by reset.
REQ-025 A requester SHALL treat gnt as acceptance of its current word; req held without gnt SHALL NOT cause a write.
REQ-026 Full and request on the same cycle: no grant, no pointer change, no memory write.

Reset
REQ-027 wrst_n low SHALL asynchronously clear wbin, wptr, wfull, rr_ptr, burst counter and wovf to 0.
REQ-028 During and after reset with req=0, gnt, wclken, wdata SHALL be 0; waddr SHALL be 0.
REQ-029 Reset asserted mid-burst or while full SHALL abandon in-flight grant; the first write after release SHALL go to waddr 0 to the lowest-indexed requester.

Configuration
REQ-030 Macro FIFO_WR_ARB_BURST_EN SHALL select burst mode.
REQ-031 With FIFO_WR_ARB_BURST_EN defined: after a write by requester k, rr_ptr SHALL stay at k until k has had BURST consecutive writes or a cycle passes without k writing; then rr_ptr=(k+1) mod NREQ and burst counter clears.
REQ-032 Without FIFO_WR_ARB_BURST_EN: pure round-robin per REQ-023; BURST unused, no burst counter implemented.

Verification (NREQ=4, ADDR=3, WIDTH=8)
REQ-033 req=0001, data 0x11..0x18 each cycle, wq2_rptr=0 -> 8 writes waddr 0..7, wfull=1 after 8th edge, wptr=4'b1100, gnt=0 thereafter, wovf=1 next edge.
REQ-034 req=1111 held, wq2_rptr tracking wptr -> gnt sequence 0001,0010,0100,1000,0001 (macro off).
REQ-035 Full state, wq2_rptr 0000->0001 -> wfull drops one edge later, exactly one further write at waddr 0, wfull re-asserts.
REQ-036 16 writes with reader keeping up -> waddr wraps 7->0 twice, wptr follows Gray sequence back to 0000, wfull never asserts.
REQ-037 Macro on, BURST=4, req=0011 held -> grants 0,0,0,0,1,1,1,1,0.
REQ-038 wrst_n pulsed low after 5 writes with req=0110 -> all registers 0 immediately; first post-reset write grants requester 1 at waddr 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Write side of an async FIFO with an N-way round-robin write arbiter.
// Define FIFO_WR_ARB_BURST_EN to let a winner keep priority for up to BURST consecutive writes.
module fifo_wr_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ADDR  = 3,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    input  logic [ADDR:0]          wq2_rptr,
    output logic [NREQ-1:0]        gnt,
    output logic                   wclken,
    output logic [WIDTH-1:0]       wdata,
    output logic [ADDR-1:0]        waddr,
    output logic [ADDR:0]          wptr,
    output logic                   wfull,
    output logic                   wovf
);

    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || BURST < 1 || ADDR < 2) begin : g_bad_params
        $error("fifo_wr_arb: unsupported parameter combination");
    end

    logic [ADDR:0]   wbin;
    logic [ADDR:0]   wbin_next;
    logic [ADDR:0]   wgray_next;
    logic [ADDR:0]   rptr_full;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic            found;

    // (base + off) mod NREQ, valid for off < NREQ
    function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Closest asserted request at or above rr_ptr; iterating downward lets the nearest win
    always_comb begin : arb_search
        winner = '0;
        found  = 1'b0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[rr_add(rr_ptr, 32'(i))]) begin
                winner = rr_add(rr_ptr, 32'(i));
                found  = 1'b1;
            end
        end
    end

    always_comb begin : grant_out
        gnt = '0;
        if (found && !wfull) gnt[winner] = 1'b1;
    end

    assign wclken = |gnt;

    always_comb begin : data_mux
        wdata = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) wdata = req_data[i*int'(WIDTH) +: WIDTH];
        end
    end

    assign waddr      = wbin[ADDR-1:0];
    assign wbin_next  = wbin + (ADDR+1)'(wclken);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the next write pointer is one lap ahead of the read pointer
    assign rptr_full  = {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin : ptr_regs
        if (!wrst_n) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
            wovf  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wptr  <= wgray_next;
            wfull <= (wgray_next == rptr_full);
            if (wfull && |req) wovf <= 1'b1;
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int unsigned BW = $clog2(BURST + 1);

    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_inc;

    // rr_ptr parks on the bursting requester, so winner==rr_ptr means it wrote again
    always_comb begin : burst_count
        bcnt_inc = BW'(1);
        if (bcnt != '0 && winner == rr_ptr) bcnt_inc = bcnt + BW'(1);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin : rr_regs
        if (!wrst_n) begin
            rr_ptr <= '0;
            bcnt   <= '0;
        end else if (wclken) begin
            if (bcnt_inc == BW'(BURST)) begin
                rr_ptr <= rr_add(winner, 32'd1);
                bcnt   <= '0;
            end else begin
                rr_ptr <= winner;
                bcnt   <= bcnt_inc;
            end
        end else if (bcnt != '0) begin
            rr_ptr <= rr_add(rr_ptr, 32'd1);
            bcnt   <= '0;
        end
    end
`else
    always_ff @(posedge wclk or negedge wrst_n) begin : rr_regs
        if (!wrst_n) begin
            rr_ptr <= '0;
        end else if (wclken) begin
            rr_ptr <= rr_add(winner, 32'd1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed and randomized checks of fifo_wr_arb against an occupancy-based reference model.
module tb_fifo_wr_arb;

    localparam int W = 8;
    localparam int A = 3;
    localparam int N = 4;
    localparam int B = 4;

    logic             wclk = 1'b0;
    logic             wrst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [A:0]       wq2_rptr;
    logic [N-1:0]     gnt;
    logic             wclken;
    logic [W-1:0]     wdata;
    logic [A-1:0]     waddr;
    logic [A:0]       wptr;
    logic             wfull;
    logic             wovf;

    fifo_wr_arb #(.WIDTH(W), .ADDR(A), .NREQ(N), .BURST(B)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
        .wq2_rptr(wq2_rptr), .gnt(gnt), .wclken(wclken), .wdata(wdata),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .wovf(wovf)
    );

    always #5 wclk = ~wclk;

    int vecs = 0;
    int errs = 0;

    // Reference state: words written / read (mod 16), arbiter priority, burst owner
    int m_wcnt, m_rcnt, m_rr, m_full, m_ovf, m_bk, m_bn;

    function automatic logic [A:0] gray(input int b);
        logic [A:0] v;
        v = (A+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_rr = 0; m_full = 0; m_ovf = 0; m_bk = -1; m_bn = 0;
    endtask

    // One clock: predict, check at the falling edge, then advance the model on the rising edge
    task automatic cyc(input string tag, output logic [N-1:0] g, output logic [A-1:0] a);
        int w;
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        wq2_rptr = gray(m_rcnt);
        w = -1;
        if (m_full == 0)
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
        eg = '0;
        ed = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ed = req_data[w*W +: W];
        end
        @(negedge wclk);
        g = gnt;
        a = waddr;
        chk({tag, "/gnt"},    32'(gnt),    32'(eg));
        chk({tag, "/wclken"}, 32'(wclken), 32'(w >= 0));
        chk({tag, "/wdata"},  32'(wdata),  32'(ed));
        chk({tag, "/waddr"},  32'(waddr),  32'(m_wcnt % 8));
        chk({tag, "/wptr"},   32'(wptr),   32'(gray(m_wcnt)));
        chk({tag, "/wfull"},  32'(wfull),  32'(m_full));
        chk({tag, "/wovf"},   32'(wovf),   32'(m_ovf));
        @(posedge wclk);
        if (m_full != 0 && req != '0) m_ovf = 1;
        if (w >= 0) m_wcnt = (m_wcnt + 1) % 16;
        m_full = ((((m_wcnt - m_rcnt) % 16) + 16) % 16) == 8;
`ifdef FIFO_WR_ARB_BURST_EN
        if (w >= 0) begin
            if (w == m_bk) m_bn++;
            else begin m_bk = w; m_bn = 1; end
            if (m_bn == B) begin m_rr = (w + 1) % N; m_bk = -1; m_bn = 0; end
            else m_rr = w;
        end else if (m_bk >= 0) begin
            m_rr = (m_bk + 1) % N; m_bk = -1; m_bn = 0;
        end
`else
        if (w >= 0) m_rr = (w + 1) % N;
`endif
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        wrst_n = 1'b0;
        model_reset();
        wq2_rptr = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
    endtask

    logic [N-1:0] g;
    logic [A-1:0] a;
    int exp_seq [9];

    initial begin
        req = '0; req_data = '0; wq2_rptr = '0; wrst_n = 1'b0;
        model_reset();
        #12;
        chk("rst/gnt",    32'(gnt),    0);
        chk("rst/wclken", 32'(wclken), 0);
        chk("rst/wdata",  32'(wdata),  0);
        chk("rst/waddr",  32'(waddr),  0);
        chk("rst/wptr",   32'(wptr),   0);
        chk("rst/wfull",  32'(wfull),  0);
        chk("rst/wovf",   32'(wovf),   0);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;

        // Single requester fills the FIFO, then overflows
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            req_data = {24'h0, 8'(8'h11 + i)};
            cyc("fill", g, a);
            chk("fill/addr", 32'(a), 32'(i));
        end
        #3;
        chk("fill/full8",  32'(wfull), 1);
        chk("fill/wptr8",  32'(wptr),  32'(4'b1100));
        cyc("ovf", g, a);
        chk("ovf/nognt", 32'(g), 0);
        #3;
        chk("ovf/sticky", 32'(wovf), 1);

        // Reader frees one slot: one more write at address 0, then full again
        m_rcnt = 1;
        cyc("drain0", g, a);
        chk("drain0/nognt", 32'(g), 0);
        cyc("drain1", g, a);
        chk("drain1/gnt",  32'(g), 32'(4'b0001));
        chk("drain1/addr", 32'(a), 0);
        req = '0;
        cyc("refull", g, a);
        #3;
        chk("refull/wfull", 32'(wfull), 1);

        // All requesters, reader keeping up: rotation and two address wraps
        do_reset();
        req = 4'b1111;
        req_data = 32'hD4C3B2A1;
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`ifdef FIFO_WR_ARB_BURST_EN
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
`endif
        for (int i = 0; i < 16; i++) begin
            m_rcnt = m_wcnt;
            cyc("rr", g, a);
            chk("rr/addr", 32'(a), 32'(i % 8));
            if (i < 9) chk("rr/seq", 32'(g), 32'(1 << exp_seq[i]));
        end
        #3;
        chk("rr/wptr0", 32'(wptr),  0);
        chk("rr/nofull", 32'(wfull), 0);

`ifdef FIFO_WR_ARB_BURST_EN
        // Two requesters under burst priority
        do_reset();
        req = 4'b0011;
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            m_rcnt = m_wcnt;
            cyc("burst", g, a);
            chk("burst/seq", 32'(g), 32'(1 << exp_seq[i]));
        end
`endif

        // Reset in the middle of a run of writes
        do_reset();
        req = 4'b0110;
        req_data = 32'h44332211;
        for (int i = 0; i < 5; i++) cyc("pre", g, a);
        #1;
        req = '0;
        wrst_n = 1'b0;
        #1;
        chk("midrst/wptr",  32'(wptr),   0);
        chk("midrst/waddr", 32'(waddr),  0);
        chk("midrst/wfull", 32'(wfull),  0);
        chk("midrst/wovf",  32'(wovf),   0);
        chk("midrst/gnt",   32'(gnt),    0);
        chk("midrst/wdata", 32'(wdata),  0);
        model_reset();
        wq2_rptr = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        req = 4'b0110;
        cyc("post", g, a);
        chk("post/gnt",  32'(g), 32'(4'b0010));
        chk("post/addr", 32'(a), 0);

        // Random requests, data and reader progress
        for (int i = 0; i < 400; i++) begin
            req = N'($urandom);
            req_data = $urandom;
            if (m_rcnt != m_wcnt && $urandom_range(0, 2) == 0) m_rcnt = (m_rcnt + 1) % 16;
            cyc("rand", g, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
